// File: rtl/reg_file_rename_if.sv
// Issue/commit/rollback inputs and dual source-operand lookup bundle of reg_file_rename.
// The master drives requests and observes lookups; the slave is the register file.
interface reg_file_rename_if #(
  parameter int unsigned RegPosW = 5,
  parameter int unsigned RobPosW = 4
);
  logic               rdy;
  logic               rollback;
  logic               issue;
  logic [RegPosW-1:0] issue_rd;
  logic [RobPosW-1:0] issue_rob_pos;
  logic               reg_write;
  logic [RegPosW-1:0] reg_rd;
  logic [31:0]        reg_val;
  logic [RobPosW-1:0] commit_rob_pos;
  logic [RegPosW-1:0] rs1;
  logic [RegPosW-1:0] rs2;
  logic               rs1_busy;
  logic [RobPosW-1:0] rs1_tag;
  logic [31:0]        rs1_val;
  logic               rs2_busy;
  logic [RobPosW-1:0] rs2_tag;
  logic [31:0]        rs2_val;

  modport master (
    output rdy, rollback, issue, issue_rd, issue_rob_pos,
    output reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    input  rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
  );

  modport slave (
    input  rdy, rollback, issue, issue_rd, issue_rob_pos,
    input  reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    output rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, fed by the ROB commit stream.
// Define REGFILE_COMMIT_BYPASS_EN to forward a same-cycle commit onto the source lookups.
module reg_file_rename #(
  parameter int unsigned RegNum  = 32,
  parameter int unsigned RegPosW = 5,
  parameter int unsigned RobPosW = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  reg_file_rename_if.slave      bus
);

  typedef struct packed {
    logic               busy;
    logic [RobPosW-1:0] tag;
    logic [31:0]        val;
  } rd_t;

  logic [31:0]        val_q  [RegNum];
  logic [RobPosW-1:0] tag_q  [RegNum];
  logic [RegNum-1:0]  busy_q;

  // x0 is only ever touched by reset, so it stays zero and never busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < RegNum; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (bus.rdy) begin
      for (int unsigned i = 1; i < RegNum; i++) begin
        if (bus.reg_write && bus.reg_rd == RegPosW'(i)) begin
          val_q[i] <= bus.reg_val;
        end
        if (bus.rollback) begin
          busy_q[i] <= 1'b0;
        end else if (bus.issue && bus.issue_rd == RegPosW'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= bus.issue_rob_pos;
        end else if (bus.reg_write && bus.reg_rd == RegPosW'(i) &&
                     tag_q[i] == bus.commit_rob_pos) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  function automatic rd_t lookup(input logic [RegPosW-1:0] idx);
    rd_t r;
    r.busy = busy_q[idx];
    r.tag  = tag_q[idx];
    r.val  = val_q[idx];
    return r;
  endfunction

  rd_t rs1_r;
  rd_t rs2_r;

  always_comb begin
    rs1_r = lookup(bus.rs1);
    rs2_r = lookup(bus.rs2);
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (bus.reg_write && bus.reg_rd == bus.rs1) begin
      rs1_r.val = bus.reg_val;
      if (rs1_r.busy && rs1_r.tag == bus.commit_rob_pos) rs1_r.busy = 1'b0;
    end
    if (bus.reg_write && bus.reg_rd == bus.rs2) begin
      rs2_r.val = bus.reg_val;
      if (rs2_r.busy && rs2_r.tag == bus.commit_rob_pos) rs2_r.busy = 1'b0;
    end
`endif
    if (!rst_ni || bus.rs1 == '0) rs1_r = '0;
    if (!rst_ni || bus.rs2 == '0) rs2_r = '0;
  end

  assign bus.rs1_busy = rs1_r.busy;
  assign bus.rs1_tag  = rs1_r.tag;
  assign bus.rs1_val  = rs1_r.val;
  assign bus.rs2_busy = rs2_r.busy;
  assign bus.rs2_tag  = rs2_r.tag;
  assign bus.rs2_val  = rs2_r.val;

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: directed scenarios then random traffic vs. a reference model.
module tb_reg_file_rename;

  logic clk;
  logic rst_n;

  reg_file_rename_if bus ();

  reg_file_rename dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] v2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Pending stimulus for the next cycle.
  logic        s_rst_n, s_rdy, s_rb, s_iss, s_wr;
  logic [4:0]  s_ird, s_wrd, s_r1, s_r2;
  logic [3:0]  s_ipos, s_cpos;
  logic [31:0] s_wval;

  // Reference model: architectural contents per register.
  logic [31:0] mval  [32];
  logic        mbusy [32];
  logic [3:0]  mtag  [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0; mbusy[i] = 1'b0; mtag[i] = '0;
    end
  endtask

  task automatic model_update();
    logic hit;
    if (s_wr && s_wrd != 0) begin
      hit = (mtag[s_wrd] == s_cpos);
      mval[s_wrd] = s_wval;
      if (hit) mbusy[s_wrd] = 1'b0;
    end
    if (s_rb) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end else if (s_iss && s_ird != 0) begin
      mbusy[s_ird] = 1'b1;
      mtag[s_ird]  = s_ipos;
    end
  endtask

  task automatic ref_read(input logic [4:0] idx, output logic b, output logic [3:0] t,
                          output logic [31:0] v);
    b = mbusy[idx]; t = mtag[idx]; v = mval[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (s_wr && s_wrd == idx) begin
      v = s_wval;
      if (b && t == s_cpos) b = 1'b0;
    end
`endif
    if (!s_rst_n || idx == 0) begin
      b = 1'b0; t = '0; v = '0;
    end
  endtask

  task automatic idle();
    s_rst_n = 1'b1; s_rdy = 1'b1; s_rb = 1'b0; s_iss = 1'b0; s_wr = 1'b0;
    s_ird = '0; s_wrd = '0; s_r1 = '0; s_r2 = '0; s_ipos = '0; s_cpos = '0; s_wval = '0;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    rst_n              = s_rst_n;
    bus.rdy            = s_rdy;
    bus.rollback       = s_rb;
    bus.issue          = s_iss;
    bus.issue_rd       = s_ird;
    bus.issue_rob_pos  = s_ipos;
    bus.reg_write      = s_wr;
    bus.reg_rd         = s_wrd;
    bus.reg_val        = s_wval;
    bus.commit_rob_pos = s_cpos;
    bus.rs1            = s_r1;
    bus.rs2            = s_r2;
    if (!s_rst_n) model_reset();
    e.r1 = s_r1;
    e.r2 = s_r2;
    ref_read(s_r1, e.b1, e.t1, e.v1);
    ref_read(s_r2, e.b2, e.t2, e.v2);
    exp_q.push_back(e);
    if (s_rst_n && s_rdy) model_update();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: lookups are combinational, so sample late in each cycle, before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("rs1_busy(x%0d)", e.r1), 32'(bus.rs1_busy), 32'(e.b1));
        chk($sformatf("rs1_tag(x%0d)", e.r1), 32'(bus.rs1_tag), 32'(e.t1));
        chk($sformatf("rs1_val(x%0d)", e.r1), bus.rs1_val, e.v1);
        chk($sformatf("rs2_busy(x%0d)", e.r2), 32'(bus.rs2_busy), 32'(e.b2));
        chk($sformatf("rs2_tag(x%0d)", e.r2), 32'(bus.rs2_tag), 32'(e.t2));
        chk($sformatf("rs2_val(x%0d)", e.r2), bus.rs2_val, e.v2);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();

    // Reset state
    s_rst_n = 1'b0; s_r1 = 5'd0; s_r2 = 5'd5; step();
    idle(); s_r1 = 5'd5; s_r2 = 5'd31; step();

    // Issue then commit
    idle(); s_iss = 1; s_ird = 5; s_ipos = 3; s_r1 = 5; step();
    idle(); s_r1 = 5; step();
    idle(); s_wr = 1; s_wrd = 5; s_cpos = 3; s_wval = 32'hDEADBEEF; s_r2 = 5; step();
    idle(); s_r1 = 5; step();

    // Stale commit
    idle(); s_iss = 1; s_ird = 5; s_ipos = 3; step();
    idle(); s_iss = 1; s_ird = 5; s_ipos = 7; step();
    idle(); s_wr = 1; s_wrd = 5; s_cpos = 3; s_wval = 32'h11; step();
    idle(); s_r1 = 5; step();

    // Same-cycle issue and commit; read during the cycle shows the old tag
    idle(); s_iss = 1; s_ird = 5; s_ipos = 3; step();
    idle(); s_iss = 1; s_ird = 5; s_ipos = 9; s_wr = 1; s_wrd = 5; s_cpos = 3;
    s_wval = 32'h22; s_r1 = 5; step();
    idle(); s_r1 = 5; step();

    // Rollback with concurrent commit and issue
    for (int i = 1; i <= 3; i++) begin
      idle(); s_iss = 1; s_ird = 5'(i); s_ipos = 4'(i + 10); step();
    end
    idle(); s_rb = 1; s_wr = 1; s_wrd = 2; s_cpos = 4'd12; s_wval = 32'h44;
    s_iss = 1; s_ird = 4; s_ipos = 6; s_r1 = 2; s_r2 = 1; step();
    idle(); s_r1 = 2; s_r2 = 4; step();
    idle(); s_r1 = 1; s_r2 = 3; step();

    // x0 is never written or busy
    idle(); s_iss = 1; s_ird = 0; s_ipos = 5; step();
    idle(); s_wr = 1; s_wrd = 0; s_wval = 32'hFF; s_cpos = 5; s_r1 = 0; step();
    idle(); s_r1 = 0; s_r2 = 0; step();

    // rdy low holds state
    idle(); s_rdy = 0; s_iss = 1; s_ird = 6; s_ipos = 2; s_wr = 1; s_wrd = 6;
    s_wval = 32'h66; step();
    idle(); s_r1 = 6; step();

    // Commit visible on a same-cycle read only with the bypass
    idle(); s_iss = 1; s_ird = 5; s_ipos = 3; step();
    idle(); s_wr = 1; s_wrd = 5; s_cpos = 3; s_wval = 32'h55; s_r2 = 5; step();
    idle(); s_r2 = 5; step();

    // Asynchronous reset mid-operation
    idle(); s_iss = 1; s_ird = 5; s_ipos = 3; step();
    idle(); s_r1 = 5; step();
    idle(); s_rst_n = 0; s_r1 = 5; s_r2 = 2; step();
    idle(); s_r1 = 5; s_r2 = 2; step();

    // Random traffic concentrated on a few registers so collisions are common
    for (int n = 0; n < 3000; n++) begin
      s_rst_n = ($urandom_range(0, 299) != 0);
      s_rdy   = ($urandom_range(0, 7) != 0);
      s_rb    = ($urandom_range(0, 15) == 0);
      s_iss   = 1'($urandom);
      s_ird   = 5'($urandom_range(0, 7));
      s_ipos  = 4'($urandom);
      s_wr    = 1'($urandom);
      s_wrd   = 5'($urandom_range(0, 7));
      s_cpos  = ($urandom_range(0, 1) != 0) ? mtag[s_wrd] : 4'($urandom);
      s_wval  = $urandom;
      s_r1    = ($urandom_range(0, 3) == 0) ? s_wrd : 5'($urandom_range(0, 7));
      s_r2    = ($urandom_range(0, 3) == 0) ? s_ird : 5'($urandom_range(0, 31));
      step();
    end

    idle(); step();
    @(negedge clk);
    #6;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
